hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Read-after-write interlock and forwarding scheduler between ID and EXE.
- Tracks in-flight destination registers in the EXE, MEM and WB stages.
- Decides each cycle whether the ID instruction may issue, and which stage forwards each source operand.
- Slots mirror pipeline valid/fire handshakes; ID uses id_stall to gate ID_ready_go.

Parameters:
- REG_AW, 5, register address width.
- STG_W, 3, width of the one-hot write-data-valid-stage code {WB,MEM,EXE}; 3'b000 means no register write.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- id_valid  in  1  ID holds a valid instruction
- id_raddr1  in  REG_AW  source register 1; 0 means unused
- id_raddr2  in  REG_AW  source register 2; 0 means unused
- id_waddr  in  REG_AW  destination register; 0 means none
- id_wstage  in  STG_W  stage at which the write data becomes valid
- flush  in  1  branch cancel; kills the ID instruction this cycle
- exe_allow_in  in  1  EXE accepts a new instruction
- exe_to_mem_fire  in  1  EXE→MEM transfer this cycle
- mem_to_wb_fire  in  1  MEM→WB transfer this cycle
- wb_retire  in  1  WB commits and empties this cycle
- id_stall  out  1  ID must hold
- issue_fire  out  1  ID→EXE transfer this cycle
- fwd_sel1  out  2  source 1 select: 0=RF, 1=EXE, 2=MEM, 3=WB
- fwd_sel2  out  2  source 2 select, same encoding
- stall_cnt  out  32  stall-cycle counter (only with the optional feature)

Behaviour:
- Reset is synchronous and active-high: reset on clk; all slot valid bits, waddr and wstage fields clear to 0; stall_cnt clears to 0.
- Reset outputs: id_stall=0, issue_fire=0, fwd_sel1=fwd_sel2=0.
- Slots E, M, W each hold {v, waddr, wstage}. A slot matches register r when v=1, waddr=r, r≠0 and wstage≠0.
- Per source r (combinational, 0-cycle latency):
  - If r=0, or no slot matches: sel=0, no hazard.
  - Otherwise take the youngest matching slot, priority E>M>W. Older matches are ignored.
  - Slot position p is E=001, M=010, W=100. The producer is ready when wstage ≤ p numerically.
  - Ready: sel=1/2/3 for E/M/W.
  - Not ready: hazard; sel is don't-care and driven 0.
- id_stall = id_valid & (hazard1 | hazard2).
- issue_fire = id_valid & ~id_stall & ~flush & exe_allow_in.
- E slot update:
  - issue_fire loads {1, id_waddr, id_wstage}; this wins over a simultaneous exe_to_mem_fire.
  - Else exe_to_mem_fire clears v.
  - Else hold.
- M slot update:
  - exe_to_mem_fire loads the E contents sampled before the edge.
  - Else mem_to_wb_fire clears v.
  - Else hold.
- W slot update:
  - mem_to_wb_fire loads the M contents sampled before the edge.
  - Else wb_retire clears v.
  - Else hold.
- All slots shift in the same cycle when all fires are asserted; no entry is lost or duplicated.
- Load-use case: a wstage=010 producer in E stalls a dependent ID instruction exactly 1 cycle; the next cycle it is in M and forwards with sel=2.
- flush with id_valid: no issue; id_stall is still computed. Slots are unaffected, because all slot entries are older than the branch.
- Reset asserted mid-operation clears all slots on that edge.

Optional Feature:
- Macro SCOREBOARD_PERF_EN.
- Defined: stall_cnt increments by 1 on every cycle with id_stall=1 and saturates at 32'hFFFF_FFFF.
- Undefined: the stall_cnt port is absent and no counter logic is built.

Decomposition:
- Shared package/header:
  - FWD_RF/FWD_EXE/FWD_MEM/FWD_WB codes.
  - STG_EXE/STG_MEM/STG_WB/STG_NONE one-hot codes.
  - Slot field width macros.
- Sub-module hazard_src_check, instantiated twice, one per source: inputs r plus the three slots; outputs sel and hazard.

Test Plan:
- No dependency:
  - Stimulus: E holds waddr=5, wstage=001; ID raddr1=3, raddr2=0.
  - Response: fwd_sel1=0, fwd_sel2=0, id_stall=0, issue_fire=1 when exe_allow_in=1.
- ALU forwarding:
  - Stimulus: E holds waddr=7, wstage=001; ID raddr1=7.
  - Response: fwd_sel1=1, id_stall=0.
- Load-use:
  - Stimulus: E holds waddr=4, wstage=010; ID raddr2=4.
  - Cycle 0 response: id_stall=1, issue_fire=0.
  - Then apply exe_to_mem_fire.
  - Cycle 1 response: fwd_sel2=2, id_stall=0.
- Youngest wins:
  - Stimulus: E holds waddr=9, wstage=001; W holds waddr=9, wstage=001; ID raddr1=9.
  - Response: fwd_sel1=1.
- r0 and flush:
  - Stimulus: E holds waddr=0 with wstage=001 and is ignored; ID raddr1=0.
  - Response: fwd_sel1=0.
  - Then assert flush with id_valid=1.
  - Response: issue_fire=0; E clears v after exe_to_mem_fire.
- Perf counter (with SCOREBOARD_PERF_EN):
  - Stimulus: 3 load-use stalls.
  - Response: stall_cnt=3.
  - Then apply reset.
  - Response: stall_cnt=0, all slots empty.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared codes and slot field widths for the RAW hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int SLOT_AW = 5;
    localparam int SLOT_SW = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [2:0] STG_NONE = 3'b000;
    localparam logic [2:0] STG_EXE  = 3'b001;
    localparam logic [2:0] STG_MEM  = 3'b010;
    localparam logic [2:0] STG_WB   = 3'b100;

endpackage

// File: rtl/hazard_src_check.sv
// rtl/hazard_src_check.sv - per-source youngest-match lookup: forward select or hazard
module hazard_src_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = SLOT_AW,
    parameter int STG_W  = SLOT_SW
) (
    input  logic [REG_AW-1:0] r,
    input  logic              e_v,
    input  logic [REG_AW-1:0] e_waddr,
    input  logic [STG_W-1:0]  e_wstage,
    input  logic              m_v,
    input  logic [REG_AW-1:0] m_waddr,
    input  logic [STG_W-1:0]  m_wstage,
    input  logic              w_v,
    input  logic [REG_AW-1:0] w_waddr,
    input  logic [STG_W-1:0]  w_wstage,
    output logic [1:0]        sel,
    output logic              hazard
);

    logic r_used;
    logic e_hit;
    logic m_hit;
    logic w_hit;

    assign r_used = (r != '0);
    assign e_hit  = r_used && e_v && (e_waddr == r) && (e_wstage != '0);
    assign m_hit  = r_used && m_v && (m_waddr == r) && (m_wstage != '0);
    assign w_hit  = r_used && w_v && (w_waddr == r) && (w_wstage != '0);

    // Youngest producer decides; its data is usable once its valid stage is not later than its slot.
    always_comb begin
        sel    = FWD_RF;
        hazard = 1'b0;
        if (e_hit) begin
            if (e_wstage <= STG_W'(STG_EXE)) sel = FWD_EXE;
            else                             hazard = 1'b1;
        end else if (m_hit) begin
            if (m_wstage <= STG_W'(STG_MEM)) sel = FWD_MEM;
            else                             hazard = 1'b1;
        end else if (w_hit) begin
            if (w_wstage <= STG_W'(STG_WB))  sel = FWD_WB;
            else                             hazard = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID/EXE RAW interlock and forwarding scheduler; SCOREBOARD_PERF_EN adds stall_cnt
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = SLOT_AW,
    parameter int STG_W  = SLOT_SW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_raddr1,
    input  logic [REG_AW-1:0] id_raddr2,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic [STG_W-1:0]  id_wstage,
    input  logic              flush,
    input  logic              exe_allow_in,
    input  logic              exe_to_mem_fire,
    input  logic              mem_to_wb_fire,
    input  logic              wb_retire,
    output logic              id_stall,
    output logic              issue_fire,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic              e_v, m_v, w_v;
    logic [REG_AW-1:0] e_waddr, m_waddr, w_waddr;
    logic [STG_W-1:0]  e_wstage, m_wstage, w_wstage;
    logic              hazard1, hazard2;

    hazard_src_check #(.REG_AW(REG_AW), .STG_W(STG_W)) u_src1 (
        .r(id_raddr1),
        .e_v(e_v), .e_waddr(e_waddr), .e_wstage(e_wstage),
        .m_v(m_v), .m_waddr(m_waddr), .m_wstage(m_wstage),
        .w_v(w_v), .w_waddr(w_waddr), .w_wstage(w_wstage),
        .sel(fwd_sel1), .hazard(hazard1)
    );

    hazard_src_check #(.REG_AW(REG_AW), .STG_W(STG_W)) u_src2 (
        .r(id_raddr2),
        .e_v(e_v), .e_waddr(e_waddr), .e_wstage(e_wstage),
        .m_v(m_v), .m_waddr(m_waddr), .m_wstage(m_wstage),
        .w_v(w_v), .w_waddr(w_waddr), .w_wstage(w_wstage),
        .sel(fwd_sel2), .hazard(hazard2)
    );

    assign id_stall   = id_valid & (hazard1 | hazard2);
    assign issue_fire = id_valid & ~id_stall & ~flush & exe_allow_in;

    // Slots mirror the pipeline handshakes; each stage reads its predecessor's pre-edge contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_v <= 1'b0; e_waddr <= '0; e_wstage <= '0;
            m_v <= 1'b0; m_waddr <= '0; m_wstage <= '0;
            w_v <= 1'b0; w_waddr <= '0; w_wstage <= '0;
        end else begin
            if (issue_fire) begin
                e_v      <= 1'b1;
                e_waddr  <= id_waddr;
                e_wstage <= id_wstage;
            end else if (exe_to_mem_fire) begin
                e_v <= 1'b0;
            end

            if (exe_to_mem_fire) begin
                m_v      <= e_v;
                m_waddr  <= e_waddr;
                m_wstage <= e_wstage;
            end else if (mem_to_wb_fire) begin
                m_v <= 1'b0;
            end

            if (mem_to_wb_fire) begin
                w_v      <= m_v;
                w_waddr  <= m_waddr;
                w_wstage <= m_wstage;
            end else if (wb_retire) begin
                w_v <= 1'b0;
            end
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (id_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_raddr1, id_raddr2, id_waddr;
    logic [2:0] id_wstage;
    logic       flush, exe_allow_in, exe_to_mem_fire, mem_to_wb_fire, wb_retire;
    logic       id_stall, issue_fire;
    logic [1:0] fwd_sel1, fwd_sel2;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        int         step;
        logic       stall;
        logic       fire;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .id_raddr1(id_raddr1),
        .id_raddr2(id_raddr2),
        .id_waddr(id_waddr),
        .id_wstage(id_wstage),
        .flush(flush),
        .exe_allow_in(exe_allow_in),
        .exe_to_mem_fire(exe_to_mem_fire),
        .mem_to_wb_fire(mem_to_wb_fire),
        .wb_retire(wb_retire),
        .id_stall(id_stall),
        .issue_fire(issue_fire),
        .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] wa, input logic [2:0] ws, input logic fl,
                        input logic al, input logic e2m, input logic m2w, input logic ret,
                        input logic st, input logic fi, input logic [1:0] s1, input logic [1:0] s2);
        exp_t e;
        id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_waddr = wa; id_wstage = ws;
        flush = fl; exe_allow_in = al; exe_to_mem_fire = e2m; mem_to_wb_fire = m2w; wb_retire = ret;
        e.step = step_no; e.stall = st; e.fire = fi; e.s1 = s1; e.s2 = s2;
        exp_q.push_back(e);
        step_no++;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (id_stall === e.stall) else begin
                errors++;
                $error("FAIL step%0d id_stall: got %b expected %b", e.step, id_stall, e.stall);
            end
            checks++;
            assert (issue_fire === e.fire) else begin
                errors++;
                $error("FAIL step%0d issue_fire: got %b expected %b", e.step, issue_fire, e.fire);
            end
            checks++;
            assert (fwd_sel1 === e.s1) else begin
                errors++;
                $error("FAIL step%0d fwd_sel1: got %0d expected %0d", e.step, fwd_sel1, e.s1);
            end
            checks++;
            assert (fwd_sel2 === e.s2) else begin
                errors++;
                $error("FAIL step%0d fwd_sel2: got %0d expected %0d", e.step, fwd_sel2, e.s2);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk); #1;
        // reset cycle and empty-slot state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        reset = 1'b0;
        step(1, 5, 3, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // no dependency
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0);
        // ALU forwarding from E
        step(1, 0, 0, 7, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0);
        step(1, 7, 7, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
        // load-use: one stall cycle, then forward from M; 7 moves to W
        step(1, 0, 0, 4, 2, 0, 1, 1, 0, 0,   0, 1, 0, 0);
        step(1, 7, 4, 0, 0, 0, 1, 1, 1, 0,   1, 0, 2, 0);
        step(1, 7, 4, 9, 1, 0, 1, 0, 0, 0,   0, 1, 3, 2);
        // youngest match wins
        step(1, 0, 0, 6, 1, 0, 1, 1, 1, 0,   0, 1, 0, 0);
        step(1, 0, 0, 9, 1, 0, 1, 1, 1, 0,   0, 1, 0, 0);
        step(1, 9, 6, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2);
        step(1, 0, 0, 9, 4, 0, 1, 1, 1, 0,   0, 1, 0, 0);
        step(1, 9, 6, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 3);
        // r0 ignored, not-ready producer in M
        step(1, 0, 0, 0, 1, 0, 1, 1, 1, 0,   0, 1, 0, 0);
        step(1, 0, 9, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        // flush blocks issue but leaves slots alone
        step(1, 0, 0, 11, 1, 0, 1, 1, 1, 0,  0, 1, 0, 0);
        step(1, 11, 9, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 3);
        step(1, 11, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0);
        step(1, 11, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
        // wb_retire empties W
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 3, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // reset mid-operation
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        reset = 1'b0;
        step(1, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SCOREBOARD_PERF_EN
        checks++;
        assert (stall_cnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_start stall_cnt: got %0d expected 0", stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 4, 2, 0, 1, 1, 1, 0, 0, 1, 0, 0);
            step(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        end
        checks++;
        assert (stall_cnt === 32'd3) else begin
            errors++;
            $error("FAIL perf_three stall_cnt: got %0d expected 3", stall_cnt);
        end
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        reset = 1'b0;
        checks++;
        assert (stall_cnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_reset stall_cnt: got %0d expected 0", stall_cnt);
        end
        step(1, 4, 4, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
